// File: rtl/svo_tmds_pkg.sv
// Shared TMDS definitions: control tokens, decoder state encoding and the decoded-symbol payload.
package svo_tmds_pkg;

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CTRL_W = 2;
    localparam int unsigned OFF_W  = 4;

    localparam logic [SYM_W-1:0] TOKEN_CTRL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOKEN_CTRL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOKEN_CTRL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOKEN_CTRL_11 = 10'b1010101011;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic              is_token;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } sym_t;

endpackage

// File: rtl/svo_tmds_dec_if.sv
// Per-channel link between deserializer/capture logic (master) and the TMDS decoder (slave).
interface svo_tmds_dec_if;
    import svo_tmds_pkg::*;

    logic [SYM_W-1:0]  din;
    logic              de;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] dout;
    logic              locked;
    logic [OFF_W-1:0]  align_offset;

    modport master (output din, input de, ctrl, dout, locked, align_offset);
    modport slave  (input din, output de, ctrl, dout, locked, align_offset);
endinterface

// File: rtl/svo_tmds_sym_dec.sv
// Combinational TMDS symbol decoder: aligned 10-bit word -> token flag, control bits, pixel byte.
module svo_tmds_sym_dec
    import svo_tmds_pkg::*;
(
    input  logic [SYM_W-1:0] aw,
    output sym_t             sym_c
);
    logic [DATA_W-1:0] q;

    always_comb begin
        sym_c = '0;
        q     = '0;
        case (aw)
            TOKEN_CTRL_00: begin sym_c.is_token = 1'b1; sym_c.ctrl = 2'b00; end
            TOKEN_CTRL_01: begin sym_c.is_token = 1'b1; sym_c.ctrl = 2'b01; end
            TOKEN_CTRL_10: begin sym_c.is_token = 1'b1; sym_c.ctrl = 2'b10; end
            TOKEN_CTRL_11: begin sym_c.is_token = 1'b1; sym_c.ctrl = 2'b11; end
            default: begin
                // Undo the optional inversion, then the XOR/XNOR transition chain.
                q             = aw[9] ? ~aw[DATA_W-1:0] : aw[DATA_W-1:0];
                sym_c.data[0] = q[0];
                for (int i = 1; i < int'(DATA_W); i++) begin
                    sym_c.data[i] = aw[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                end
            end
        endcase
    end
endmodule

// File: rtl/svo_tmds_dec.sv
// TMDS channel decoder: hunts bit alignment on runs of control tokens, then decodes symbols.
module svo_tmds_dec
    import svo_tmds_pkg::*;
#(
    parameter int unsigned LOCK_TOKENS    = 16,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOSS_WORDS     = 4096
) (
    input logic           clk,
    input logic           resetn,
    svo_tmds_dec_if.slave bus
);
    localparam int unsigned RUN_W  = $clog2(LOCK_TOKENS) + 1;
    localparam int unsigned TMO_W  = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int unsigned IDLE_W = $clog2(LOSS_WORDS) + 1;
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(SYM_W - 1);

    logic [SYM_W-1:0]  prev_q, prev_d, aw_q, aw_d;
    logic [OFF_W-1:0]  off_q, off_d;
    state_e            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              skip_q, skip_d;
    logic              de_q, de_d, locked_q, locked_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              token_ok;
    sym_t              sym;

    svo_tmds_sym_dec u_sym_dec (.aw(aw_q), .sym_c(sym));

    // Bit off_q of the {din, prev} stream becomes aw[0].
    always_comb begin
        prev_d = bus.din;
        aw_d   = SYM_W'({bus.din, prev_q} >> off_q);
    end

    // The word right after an offset change was captured at the old offset; never count it.
    assign token_ok = sym.is_token && !skip_q;

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        run_d   = run_q;
        tmo_d   = tmo_q;
        idle_d  = idle_q;
        skip_d  = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                tmo_d = tmo_q + 1'b1;
                run_d = token_ok ? run_q + 1'b1 : '0;
                if (token_ok && run_q == RUN_W'(LOCK_TOKENS - 1)) begin
                    state_d = ST_LOCKED;
                    run_d   = '0;
                    tmo_d   = '0;
                    idle_d  = '0;
                end else if (tmo_q == TMO_W'(SEARCH_TIMEOUT - 1)) begin
                    off_d  = (off_q == OFF_MAX) ? '0 : off_q + 1'b1;
                    run_d  = '0;
                    tmo_d  = '0;
                    skip_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (sym.is_token) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(LOSS_WORDS - 1)) begin
                    state_d = ST_SEARCH;
                    run_d   = '0;
                    tmo_d   = '0;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs are gated by the next state so locked and symbol outputs change together.
    always_comb begin
        locked_d = (state_d == ST_LOCKED);
        de_d     = locked_d && !sym.is_token;
        ctrl_d   = locked_d ? sym.ctrl : '0;
        dout_d   = de_d ? sym.data : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q   <= '0;
            aw_q     <= '0;
            off_q    <= '0;
            state_q  <= ST_SEARCH;
            run_q    <= '0;
            tmo_q    <= '0;
            idle_q   <= '0;
            skip_q   <= 1'b0;
            de_q     <= 1'b0;
            ctrl_q   <= '0;
            dout_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            aw_q     <= aw_d;
            off_q    <= off_d;
            state_q  <= state_d;
            run_q    <= run_d;
            tmo_q    <= tmo_d;
            idle_q   <= idle_d;
            skip_q   <= skip_d;
            de_q     <= de_d;
            ctrl_q   <= ctrl_d;
            dout_q   <= dout_d;
            locked_q <= locked_d;
        end
    end

    assign bus.de           = de_q;
    assign bus.ctrl         = ctrl_q;
    assign bus.dout         = dout_q;
    assign bus.locked       = locked_q;
    assign bus.align_offset = off_q;
endmodule
